// File: rtl/keypad_scan_if.sv
// Keypad scanner signal bundle: matrix row/column lines plus the key event outputs.
// The scanner uses the master side; whatever owns the physical keypad or consumes
// the key events (board wrapper, testbench) uses the slave side.
interface keypad_scan_if;
    logic [3:0] col_in;
    logic [3:0] row_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_pressed;

    modport master (
        input  col_in,
        output row_out,
        output key_code,
        output key_valid,
        output key_pressed
    );

    modport slave (
        output col_in,
        input  row_out,
        input  key_code,
        input  key_valid,
        input  key_pressed
    );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 active-low matrix keypad scanner.
// Drives one row low at a time and samples the columns on a slow tick. It
// debounces both press and release, and reports one key event per physical
// press: a one-cycle key_valid strobe plus a key_pressed level held until the
// release is accepted.
module keypad_scan #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_TICKS = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    keypad_scan_if.master kp
);

    localparam int               DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [7:0]       DEB_LAST = 8'(DEBOUNCE_TICKS);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       col_meta, col_s;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [3:0]       col_low;
    logic             hit_single;
    logic [1:0]       hit_col;

    logic [7:0]       deb_cnt, deb_cnt_d;
    logic [1:0]       row_idx, row_idx_d;
    logic [1:0]       key_row, key_row_d;
    logic [1:0]       key_col, key_col_d;
    logic [3:0]       row_out_q;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic             key_pressed_q, key_pressed_d;

    // Two-flop synchroniser for the asynchronous column lines (idle level is all ones).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_meta <= 4'hF;
            col_s    <= 4'hF;
        end else begin
            col_meta <= kp.col_in;
            col_s    <= col_meta;
        end
    end

    // Free-running scan divider; tick marks the last count of each period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign tick = (div_cnt == DIV_LAST);

    // Classify the column sample: exactly one low column is a usable hit.
    always_comb begin
        col_low    = ~col_s;
        hit_single = (col_low != 4'd0) && ((col_low & (col_low - 4'd1)) == 4'd0);
        hit_col    = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (col_low[i]) begin
                hit_col = 2'(i);
            end
        end
    end

    // Scan/debounce/held sequencing; every decision is taken on a tick only.
    always_comb begin
        state_d       = state_q;
        deb_cnt_d     = deb_cnt;
        row_idx_d     = row_idx;
        key_row_d     = key_row;
        key_col_d     = key_col;
        key_code_d    = key_code_q;
        key_valid_d   = 1'b0;
        key_pressed_d = key_pressed_q;

        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (hit_single) begin
                        key_row_d = row_idx;
                        key_col_d = hit_col;
                        deb_cnt_d = 8'd1;
                        state_d   = DEBOUNCE;
                    end else begin
                        row_idx_d = row_idx + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (hit_single && (hit_col == key_col)) begin
                        if (deb_cnt + 8'd1 == DEB_LAST) begin
                            key_code_d    = {key_row, key_col};
                            key_valid_d   = 1'b1;
                            key_pressed_d = 1'b1;
                            deb_cnt_d     = 8'd0;
                            state_d       = HELD;
                        end else begin
                            deb_cnt_d = deb_cnt + 8'd1;
                        end
                    end else begin
                        deb_cnt_d = 8'd0;
                        row_idx_d = row_idx + 2'd1;
                        state_d   = SCAN;
                    end
                end
                HELD: begin
                    if (col_s[key_col]) begin
                        if (deb_cnt + 8'd1 == DEB_LAST) begin
                            key_pressed_d = 1'b0;
                            deb_cnt_d     = 8'd0;
                            row_idx_d     = row_idx + 2'd1;
                            state_d       = SCAN;
                        end else begin
                            deb_cnt_d = deb_cnt + 8'd1;
                        end
                    end else begin
                        deb_cnt_d = 8'd0;
                    end
                end
                default: begin
                    deb_cnt_d = 8'd0;
                    state_d   = SCAN;
                end
            endcase
        end
    end

    // State, counters and registered outputs; row drive is decoded from the next row index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= SCAN;
            deb_cnt       <= 8'd0;
            row_idx       <= 2'd0;
            key_row       <= 2'd0;
            key_col       <= 2'd0;
            row_out_q     <= 4'b1110;
            key_code_q    <= 4'd0;
            key_valid_q   <= 1'b0;
            key_pressed_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            deb_cnt       <= deb_cnt_d;
            row_idx       <= row_idx_d;
            key_row       <= key_row_d;
            key_col       <= key_col_d;
            row_out_q     <= ~(4'b0001 << row_idx_d);
            key_code_q    <= key_code_d;
            key_valid_q   <= key_valid_d;
            key_pressed_q <= key_pressed_d;
        end
    end

    assign kp.row_out     = row_out_q;
    assign kp.key_code    = key_code_q;
    assign kp.key_valid   = key_valid_q;
    assign kp.key_pressed = key_pressed_q;

endmodule
